// File: rtl/clkdiv_pkg.sv
// Shared constants and helper functions for the programmable clock divider.
package clkdiv_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned DIV_MIN   = 2;

  function automatic int unsigned clamp_div(input int unsigned d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

  function automatic int unsigned high_cnt(input int unsigned d);
    return (d + 1) >> 1;
  endfunction

  // Channel i resets to divide-by-2^(i+1), limited to the largest divisor the counter holds.
  function automatic int unsigned reset_div(input int unsigned i, input int unsigned w);
    int unsigned pow2;
    int unsigned dmax;
    pow2 = 32'd1 << (i + 1);
    dmax = (32'd1 << w) - 1;
    return (pow2 < dmax) ? pow2 : dmax;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow divisor pair and registered outputs.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned CntW   = 8,
  parameter int unsigned RstDiv = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            sync_i,
  input  logic            cfg_we_i,
  input  logic [CntW-1:0] cfg_div_i,
  output logic            pend_o,
  output logic            div_out_o,
  output logic            div_tick_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] act_div_q, act_div_d;
  logic [CntW-1:0] shd_div_q, shd_div_d;
  logic            pend_q, pend_d;
  logic            out_q, out_d;
  logic            tick_q, tick_d;
  logic            wrap;
  logic [CntW-1:0] high_w;

  assign wrap   = (cnt_q == act_div_q - CntW'(1));
  assign high_w = CntW'(high_cnt(32'(act_div_q)));

  always_comb begin
    cnt_d     = cnt_q;
    act_div_d = act_div_q;
    shd_div_d = shd_div_q;
    pend_d    = pend_q;
    out_d     = out_q;
    tick_d    = tick_q;

    if (en_i && sync_i) begin
      cnt_d     = '0;
      out_d     = 1'b1;
      tick_d    = 1'b0;
      act_div_d = shd_div_q;
      pend_d    = 1'b0;
    end else if (!en_i) begin
      cnt_d     = '0;
      out_d     = 1'b0;
      tick_d    = 1'b0;
      act_div_d = shd_div_q;
      pend_d    = 1'b0;
    end else begin
      out_d  = (cnt_q < high_w);
      tick_d = wrap;
      cnt_d  = wrap ? '0 : cnt_q + CntW'(1);
      if (wrap) begin
        act_div_d = shd_div_q;
        pend_d    = 1'b0;
      end
    end

    // Applied last so a write landing on an update edge defers to the following one.
    if (cfg_we_i) begin
      shd_div_d = CntW'(clamp_div(32'(cfg_div_i)));
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      act_div_q <= CntW'(RstDiv);
      shd_div_q <= CntW'(RstDiv);
      pend_q    <= 1'b0;
      out_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      act_div_q <= act_div_d;
      shd_div_q <= shd_div_d;
      pend_q    <= pend_d;
      out_q     <= out_d;
      tick_q    <= tick_d;
    end
  end

  assign pend_o     = pend_q;
  assign div_out_o  = out_q;
  assign div_tick_o = tick_q;

endmodule

// File: rtl/clock_divider_prog.sv
// Multi-channel programmable clock divider with a ready/valid divisor config port.
module clock_divider_prog
  import clkdiv_pkg::*;
#(
  parameter  int unsigned NUM_CH = 5,
  parameter  int unsigned CNT_W  = CNT_W_DEF,
  localparam int unsigned ChW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ChW-1:0]    cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] div_out,
  output logic [NUM_CH-1:0] div_tick
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] cfg_we;

  // Unmapped channel numbers read as ready so the master never stalls on them.
  always_comb begin
    cfg_ready = 1'b1;
    cfg_we    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == ChW'(i)) begin
        cfg_ready = ~pend[i];
        cfg_we[i] = cfg_valid & ~pend[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkdiv_channel #(
      .CntW   (CNT_W),
      .RstDiv (reset_div(g, CNT_W))
    ) u_ch (
      .clk_i      (clk),
      .rst_ni     (reset),
      .en_i       (ch_en[g]),
      .sync_i     (sync),
      .cfg_we_i   (cfg_we[g]),
      .cfg_div_i  (cfg_div),
      .pend_o     (pend[g]),
      .div_out_o  (div_out[g]),
      .div_tick_o (div_tick[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed self-checking bench for clock_divider_prog with default parameters.
module tb_clock_divider_prog;

  localparam int NCH = 5;

  logic           clk;
  logic           reset;
  logic [NCH-1:0] ch_en;
  logic           sync;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [2:0]     cfg_ch;
  logic [7:0]     cfg_div;
  logic [NCH-1:0] div_out;
  logic [NCH-1:0] div_tick;

  int n_cmp;
  int n_err;
  int divs [NCH];

  clock_divider_prog #(
    .NUM_CH (NCH),
    .CNT_W  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_en     (ch_en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .div_out   (div_out),
    .div_tick  (div_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for one channel at period phase ph (edges counted from restart).
  task automatic chk_ch(input string tag, input int ch, input int d, input int ph);
    int eo;
    int et;
    eo = ((ph % d) < ((d + 1) / 2)) ? 1 : 0;
    et = ((ph % d) == (d - 1)) ? 1 : 0;
    check_eq({tag, "_out"}, 32'(div_out[ch]), eo);
    check_eq({tag, "_tick"}, 32'(div_tick[ch]), et);
  endtask

  task automatic chk_all(input string tag, input int ph);
    logic [NCH-1:0] eo;
    logic [NCH-1:0] et;
    for (int i = 0; i < NCH; i++) begin
      eo[i] = ((ph % divs[i]) < ((divs[i] + 1) / 2));
      et[i] = ((ph % divs[i]) == (divs[i] - 1));
    end
    check_eq({tag, "_out"}, 32'(div_out), 32'(eo));
    check_eq({tag, "_tick"}, 32'(div_tick), 32'(et));
  endtask

  initial begin
    int t0;
    int t4;
    int found;
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b0;
    ch_en     = '0;
    sync      = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = 3'd0;
    cfg_div   = 8'd0;
    divs      = '{2, 4, 8, 16, 32};

    // Reset defaults
    repeat (3) begin
      step();
      check_eq("rst_out", 32'(div_out), 0);
      check_eq("rst_tick", 32'(div_tick), 0);
    end
    reset = 1'b1;
    ch_en = '1;
    t0 = 0;
    t4 = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      chk_all("dflt", k);
      if (div_tick[0]) t0++;
      if (div_tick[4]) t4++;
    end
    check_eq("dflt_ticks_ch0", t0, 32);
    check_eq("dflt_ticks_ch4", t4, 2);

    // Out-of-range channel: always ready, write dropped
    cfg_valid = 1'b1;
    cfg_ch    = 3'd7;
    cfg_div   = 8'd9;
    #1 check_eq("oor_ready", 32'(cfg_ready), 1);
    step();
    check_eq("oor_ready_after", 32'(cfg_ready), 1);
    cfg_valid = 1'b0;

    // Odd divisor on ch1, written while disabled
    ch_en[1]  = 1'b0;
    cfg_valid = 1'b1;
    cfg_ch    = 3'd1;
    cfg_div   = 8'd5;
    #1 check_eq("odd_ready0", 32'(cfg_ready), 1);
    step();
    check_eq("odd_pend", 32'(cfg_ready), 0);
    cfg_valid = 1'b0;
    step();
    check_eq("odd_ready1", 32'(cfg_ready), 1);
    check_eq("odd_off", 32'(div_out[1]), 0);
    ch_en[1] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      chk_ch("odd5", 1, 5, k);
    end

    // Mid-period reconfig on ch2: 8 -> 3, written at cnt=2
    ch_en[2] = 1'b0;
    step();
    ch_en[2] = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      if (k < 8) chk_ch("recfg8", 2, 8, k);
      else       chk_ch("recfg3", 2, 3, k - 8);
      if (k == 1) begin
        cfg_valid = 1'b1;
        cfg_ch    = 3'd2;
        cfg_div   = 8'd3;
        #1 check_eq("recfg_ready", 32'(cfg_ready), 1);
      end
      if (k == 2) begin
        check_eq("recfg_pend", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
      end
      if (k == 6) check_eq("recfg_pend_hold", 32'(cfg_ready), 0);
      if (k == 7) check_eq("recfg_pend_clr", 32'(cfg_ready), 1);
    end

    // Handshake stall on ch3: 16 -> 6 -> 10
    ch_en[3] = 1'b0;
    step();
    ch_en[3] = 1'b1;
    for (int k = 0; k < 42; k++) begin
      step();
      if (k < 16)      chk_ch("stall16", 3, 16, k);
      else if (k < 22) chk_ch("stall6", 3, 6, k - 16);
      else             chk_ch("stall10", 3, 10, k - 22);
      if (k == 1) begin
        cfg_valid = 1'b1;
        cfg_ch    = 3'd3;
        cfg_div   = 8'd6;
        #1 check_eq("stall_ready_a", 32'(cfg_ready), 1);
      end
      if (k == 2) begin
        check_eq("stall_busy", 32'(cfg_ready), 0);
        cfg_div = 8'd10;
      end
      if (k == 14) check_eq("stall_busy_late", 32'(cfg_ready), 0);
      if (k == 15) check_eq("stall_ready_b", 32'(cfg_ready), 1);
      if (k == 16) begin
        check_eq("stall_busy_b", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
      end
    end

    // Clamp 0/1 to 2, then sync all channels
    cfg_valid = 1'b1;
    cfg_ch    = 3'd0;
    cfg_div   = 8'd0;
    #1 check_eq("clamp_ready0", 32'(cfg_ready), 1);
    step();
    cfg_ch  = 3'd1;
    cfg_div = 8'd1;
    #1 check_eq("clamp_ready1", 32'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0;
    sync      = 1'b1;
    step();
    sync = 1'b0;
    check_eq("sync_out", 32'(div_out), 32'h1f);
    check_eq("sync_tick", 32'(div_tick), 0);
    divs = '{2, 2, 3, 10, 32};
    for (int k = 0; k < 20; k++) begin
      step();
      chk_all("sync", k);
    end

    // Reset during a high phase of ch4, with a pending shadow write
    cfg_valid = 1'b1;
    cfg_ch    = 3'd4;
    cfg_div   = 8'd7;
    #1 check_eq("mid_ready", 32'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      step();
      if (div_out[4]) found = 1;
    end
    check_eq("mid_high_found", found, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_out", 32'(div_out), 0);
    check_eq("async_tick", 32'(div_tick), 0);
    divs = '{2, 4, 8, 16, 32};
    repeat (2) begin
      step();
      check_eq("rst2_hold", 32'(div_out), 0);
    end
    reset = 1'b1;
    for (int k = 0; k < 64; k++) begin
      step();
      chk_all("rst2", k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
